mc_cu: RTL and testbench
========================

// Module: mc_cu
// PURPOSE
//  Multi-cycle control unit for the MIPS-subset CPU, successor to the single-cycle decoder.
//  FSM sequences each instruction through IF/ID/EXE/MEM/WB so that one shared ALU and one
//  shared memory port are time-multiplexed. Adds a memory ready handshake, illegal-opcode
//  halt and a retired-instruction counter. Sits between the IR/ALU datapath and the memory.
// PARAMETERS
//  CNT_W          32  width of retired-instruction counter instret
//  MEM_HANDSHAKE  1   1: IF/MEM wait for mem_ready; 0: mem_ready ignored (treated as 1)
// PORTS
//  clock      in   1      system clock, rising edge
//  reset      in   1      asynchronous, active-high reset
//  op         in   6      IR[31:26]
//  func       in   6      IR[5:0]
//  z          in   1      ALU zero flag (valid in EXE)
//  mem_ready  in   1      memory has completed current read/write this cycle
//  wpc        out  1      PC write enable
//  wir        out  1      IR write enable
//  wmem       out  1      memory write request
//  wreg       out  1      register file write enable
//  iord       out  1      memory address select: 0=PC, 1=ALU result register
//  regrt      out  1      destination select: 1=rt, 0=rd
//  m2reg      out  1      writeback select: 1=memory data, 0=ALU result
//  jal        out  1      force destination r31 and write data=PC
//  shift      out  1      ALU A = sa field
//  sext       out  1      immediate sign-extend (0=zero-extend)
//  alusrca    out  1      ALU A: 0=PC, 1=rs (overridden by shift)
//  alusrcb    out  2      ALU B: 00=rt, 01=const 4, 10=ext imm, 11=ext imm<<2
//  aluc       out  4      ALU function code
//  pcsource   out  2      00=ALU(PC+4), 01=branch target reg, 10=rs (jr), 11=jump addr
//  state      out  3      current state: IF=0 ID=1 EXE=2 MEM=3 WB=4 HALT=5
//  halted     out  1      1 while in HALT
//  instret    out  CNT_W  retired-instruction count
// BEHAVIOUR
//  Reset (async): state=IF, instret=0; all strobes deassert combinationally from state.
//  Supported: add sub and or xor sll srl sra jr addi andi ori xori lw sw beq bne lui j jal.
//  aluc: add 0000, sub 0100, and 0001, or 0101, xor 0010, lui 0110, sll 0011, srl 0111,
//   sra 1111; andi/ori/xori use and/or/xor codes; lw/sw/addi use add; beq/bne use sub.
//  sext=1 only for addi, lw, sw, beq, bne.
//  Outputs are combinational from state, op, func, z, mem_ready; only state and
//   instret are registered. Any strobe not listed for a state is 0.
//  IF : iord=0, alusrca=0, alusrcb=01, aluc=add, pcsource=00. If ready: wir=1, wpc=1,
//   ->ID; else hold IF, wir=wpc=0. ready = mem_ready | ~MEM_HANDSHAKE.
//  ID : alusrca=0, alusrcb=11, aluc=add (branch target latched by datapath).
//   j: wpc=1, pcsource=11 ->IF. jal: wpc=1, pcsource=11, wreg=1, jal=1 ->IF.
//   jr: wpc=1, pcsource=10 ->IF. illegal op/func: ->HALT, no writes. Else ->EXE.
//  EXE: alusrca=1; alusrcb=00 for R-type/beq/bne, 10 otherwise; shift for sll/srl/sra.
//   beq/bne: pcsource=01, wpc=(beq&z)|(bne&~z) ->IF. lw/sw ->MEM. Others ->WB.
//  MEM: iord=1. sw: wmem=1 held until ready, ->IF on ready. lw: ->WB on ready.
//   Not ready: hold MEM, all inputs of the request stable.
//  WB : wreg=1; regrt=1 for I-type; m2reg=1 only for lw. ->IF.
//  HALT: absorbing; all strobes 0; exit only by reset.
//  instret += 1 (wraps mod 2^CNT_W) on every transition into IF from ID/EXE/MEM/WB.
//  Latency (ready=1): j/jal/jr 2, beq/bne 3, R/I-ALU 4, sw 4, lw 5 cycles.
//  Reset mid-instruction aborts it immediately; not counted; wmem/wreg drop same cycle.
//  mem_ready outside IF/MEM is ignored.
// TESTING
//  add (op=0,func=100000), ready=1 -> states 0,1,2,4,0; wreg=1 only in WB, regrt=0,
//   aluc=0000; instret 0->1.
//  lw (op=100011), mem_ready low 3 cycles in MEM -> MEM held 4 cycles, iord=1 throughout,
//   then WB with m2reg=1, regrt=1; 8 cycles total.
//  beq z=1 -> wpc=1, pcsource=01 in EXE; beq z=0 -> wpc=0 in EXE; bne inverse; both ->IF.
//  jal -> in ID wpc=1, pcsource=11, wreg=1, jal=1; next state IF; 2 cycles.
//  op=111111 -> HALT after ID, halted=1, all strobes 0 for 20 cycles; reset -> IF,
//   instret=0.
//  Assert reset during MEM of sw with wmem=1 -> wmem=0 asynchronously, state=IF;
//   CNT_W=4 run 17 adds -> instret=1 (wrap).

Source files
------------

// File: rtl/mc_cu.sv
// Multi-cycle control unit: sequences each instruction through IF/ID/EXE/MEM/WB,
// time-multiplexing one ALU and one memory port, with illegal-opcode halt and retire counter.
module mc_cu #(
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned MEM_HANDSHAKE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             z,
  input  logic             mem_ready,
  output logic             wpc,
  output logic             wir,
  output logic             wmem,
  output logic             wreg,
  output logic             iord,
  output logic             regrt,
  output logic             m2reg,
  output logic             jal,
  output logic             shift,
  output logic             sext,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [3:0]       aluc,
  output logic [1:0]       pcsource,
  output logic [2:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    StIf   = 3'd0,
    StId   = 3'd1,
    StExe  = 3'd2,
    StMem  = 3'd3,
    StWb   = 3'd4,
    StHalt = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic ready;
  logic r_type, is_add, is_sub, is_and, is_or, is_xor, is_sll, is_srl, is_sra, is_jr;
  logic is_addi, is_andi, is_ori, is_xori, is_lui, is_lw, is_sw, is_beq, is_bne, is_j, is_jal;
  logic is_shift, is_branch, legal, sext_dec, retire;
  logic [3:0] aluc_dec;

  assign ready = mem_ready || (MEM_HANDSHAKE == 0);

  assign r_type  = (op == 6'b000000);
  assign is_add  = r_type && (func == 6'b100000);
  assign is_sub  = r_type && (func == 6'b100010);
  assign is_and  = r_type && (func == 6'b100100);
  assign is_or   = r_type && (func == 6'b100101);
  assign is_xor  = r_type && (func == 6'b100110);
  assign is_sll  = r_type && (func == 6'b000000);
  assign is_srl  = r_type && (func == 6'b000010);
  assign is_sra  = r_type && (func == 6'b000011);
  assign is_jr   = r_type && (func == 6'b001000);
  assign is_addi = (op == 6'b001000);
  assign is_andi = (op == 6'b001100);
  assign is_ori  = (op == 6'b001101);
  assign is_xori = (op == 6'b001110);
  assign is_lui  = (op == 6'b001111);
  assign is_lw   = (op == 6'b100011);
  assign is_sw   = (op == 6'b101011);
  assign is_beq  = (op == 6'b000100);
  assign is_bne  = (op == 6'b000101);
  assign is_j    = (op == 6'b000010);
  assign is_jal  = (op == 6'b000011);

  assign is_shift  = is_sll | is_srl | is_sra;
  assign is_branch = is_beq | is_bne;
  assign sext_dec  = is_addi | is_lw | is_sw | is_beq | is_bne;
  assign legal = is_add | is_sub | is_and | is_or | is_xor | is_shift | is_jr |
                 is_addi | is_andi | is_ori | is_xori | is_lui | is_lw | is_sw |
                 is_branch | is_j | is_jal;

  always_comb begin
    aluc_dec = 4'b0000;
    if (is_sub || is_branch)       aluc_dec = 4'b0100;
    else if (is_and || is_andi)    aluc_dec = 4'b0001;
    else if (is_or || is_ori)      aluc_dec = 4'b0101;
    else if (is_xor || is_xori)    aluc_dec = 4'b0010;
    else if (is_lui)               aluc_dec = 4'b0110;
    else if (is_sll)               aluc_dec = 4'b0011;
    else if (is_srl)               aluc_dec = 4'b0111;
    else if (is_sra)               aluc_dec = 4'b1111;
  end

  always_comb begin
    state_d  = state_q;
    wpc      = 1'b0;
    wir      = 1'b0;
    wmem     = 1'b0;
    wreg     = 1'b0;
    iord     = 1'b0;
    regrt    = 1'b0;
    m2reg    = 1'b0;
    jal      = 1'b0;
    shift    = 1'b0;
    sext     = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    aluc     = 4'b0000;
    pcsource = 2'b00;
    case (state_q)
      StIf: begin
        alusrcb = 2'b01;
        if (ready) begin
          wir     = 1'b1;
          wpc     = 1'b1;
          state_d = StId;
        end
      end
      StId: begin
        // ALU forms PC+4+(imm<<2) here so the datapath can latch the branch target.
        alusrcb = 2'b11;
        sext    = sext_dec;
        if (!legal) begin
          state_d = StHalt;
        end else if (is_j || is_jal) begin
          wpc      = 1'b1;
          pcsource = 2'b11;
          wreg     = is_jal;
          jal      = is_jal;
          state_d  = StIf;
        end else if (is_jr) begin
          wpc      = 1'b1;
          pcsource = 2'b10;
          state_d  = StIf;
        end else begin
          state_d = StExe;
        end
      end
      StExe: begin
        alusrca = 1'b1;
        alusrcb = (r_type || is_branch) ? 2'b00 : 2'b10;
        shift   = is_shift;
        aluc    = aluc_dec;
        sext    = sext_dec;
        if (is_branch) begin
          pcsource = 2'b01;
          wpc      = (is_beq & z) | (is_bne & ~z);
          state_d  = StIf;
        end else if (is_lw || is_sw) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        iord = 1'b1;
        sext = sext_dec;
        wmem = is_sw;
        if (ready) state_d = is_sw ? StIf : StWb;
      end
      StWb: begin
        wreg    = 1'b1;
        regrt   = ~r_type;
        m2reg   = is_lw;
        state_d = StIf;
      end
      StHalt: state_d = StHalt;
      default: state_d = StIf;
    endcase
  end

  assign retire = (state_q == StId || state_q == StExe || state_q == StMem || state_q == StWb) &&
                  (state_d == StIf);

  always_comb begin
    instret_d = instret_q;
    if (retire) instret_d = instret_q + CNT_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIf;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  assign state   = state_q;
  assign halted  = (state_q == StHalt);
  assign instret = instret_q;

endmodule

// File: tb/tb_mc_cu.sv
// Bench for mc_cu: instruction table with latency/decode checks, directed corner sequences
// and randomized instruction streams checked against a per-instruction phase-schedule model.
module tb_mc_cu;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] op = 6'd0, func = 6'd0;
  logic       z = 1'b0, mem_ready = 1'b0;

  logic wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, shift, sext, alusrca, halted;
  logic [1:0] alusrcb, pcsource;
  logic [3:0] aluc;
  logic [2:0] state;
  logic [31:0] instret;

  logic wpc4, wir4, wmem4, wreg4, iord4, regrt4, m2reg4, jal4, shift4, sext4, alusrca4, halted4;
  logic [1:0] alusrcb4, pcsource4;
  logic [3:0] aluc4;
  logic [2:0] state4;
  logic [3:0] instret4;

  always #5 clock = ~clock;

  mc_cu #(.CNT_W(32), .MEM_HANDSHAKE(1)) dut (
    .clock(clock), .reset(reset), .op(op), .func(func), .z(z), .mem_ready(mem_ready),
    .wpc(wpc), .wir(wir), .wmem(wmem), .wreg(wreg), .iord(iord), .regrt(regrt),
    .m2reg(m2reg), .jal(jal), .shift(shift), .sext(sext), .alusrca(alusrca),
    .alusrcb(alusrcb), .aluc(aluc), .pcsource(pcsource), .state(state), .halted(halted),
    .instret(instret)
  );

  mc_cu #(.CNT_W(4), .MEM_HANDSHAKE(1)) dut4 (
    .clock(clock), .reset(reset), .op(op), .func(func), .z(z), .mem_ready(mem_ready),
    .wpc(wpc4), .wir(wir4), .wmem(wmem4), .wreg(wreg4), .iord(iord4), .regrt(regrt4),
    .m2reg(m2reg4), .jal(jal4), .shift(shift4), .sext(sext4), .alusrca(alusrca4),
    .alusrcb(alusrcb4), .aluc(aluc4), .pcsource(pcsource4), .state(state4),
    .halted(halted4), .instret(instret4)
  );

  typedef struct packed {
    logic [2:0] state;
    logic       halted, wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, shift, sext, alusrca;
    logic [1:0] alusrcb;
    logic [3:0] aluc;
    logic [1:0] pcsource;
  } out_t;

  typedef struct {
    string      nm;
    logic [5:0] op;
    logic [5:0] func;
    logic [3:0] aluc;
    logic       sext;
    int         lat;
  } vec_t;

  vec_t        vt[20];
  int          n_pass = 0, n_chk = 0;
  int unsigned cnt_exp = 0;
  int          rdy_pct = 100, zmode = 0, mem_stall = 0;

  task automatic fill_table();
    vt[0]  = '{"add",  6'b000000, 6'b100000, 4'b0000, 1'b0, 4};
    vt[1]  = '{"sub",  6'b000000, 6'b100010, 4'b0100, 1'b0, 4};
    vt[2]  = '{"and",  6'b000000, 6'b100100, 4'b0001, 1'b0, 4};
    vt[3]  = '{"or",   6'b000000, 6'b100101, 4'b0101, 1'b0, 4};
    vt[4]  = '{"xor",  6'b000000, 6'b100110, 4'b0010, 1'b0, 4};
    vt[5]  = '{"sll",  6'b000000, 6'b000000, 4'b0011, 1'b0, 4};
    vt[6]  = '{"srl",  6'b000000, 6'b000010, 4'b0111, 1'b0, 4};
    vt[7]  = '{"sra",  6'b000000, 6'b000011, 4'b1111, 1'b0, 4};
    vt[8]  = '{"jr",   6'b000000, 6'b001000, 4'b0000, 1'b0, 2};
    vt[9]  = '{"addi", 6'b001000, 6'b101010, 4'b0000, 1'b1, 4};
    vt[10] = '{"andi", 6'b001100, 6'b101010, 4'b0001, 1'b0, 4};
    vt[11] = '{"ori",  6'b001101, 6'b101010, 4'b0101, 1'b0, 4};
    vt[12] = '{"xori", 6'b001110, 6'b101010, 4'b0010, 1'b0, 4};
    vt[13] = '{"lui",  6'b001111, 6'b101010, 4'b0110, 1'b0, 4};
    vt[14] = '{"lw",   6'b100011, 6'b101010, 4'b0000, 1'b1, 5};
    vt[15] = '{"sw",   6'b101011, 6'b101010, 4'b0000, 1'b1, 4};
    vt[16] = '{"beq",  6'b000100, 6'b101010, 4'b0100, 1'b1, 3};
    vt[17] = '{"bne",  6'b000101, 6'b101010, 4'b0100, 1'b1, 3};
    vt[18] = '{"j",    6'b000010, 6'b101010, 4'b0000, 1'b0, 2};
    vt[19] = '{"jal",  6'b000011, 6'b101010, 4'b0000, 1'b0, 2};
  endtask

  function automatic int find(input logic [5:0] o, input logic [5:0] f);
    for (int i = 0; i < 20; i++)
      if (vt[i].op == o && (o != 6'd0 || vt[i].func == f)) return i;
    return -1;
  endfunction

  function automatic out_t act(input bit four);
    out_t a;
    if (four) a = '{state4, halted4, wpc4, wir4, wmem4, wreg4, iord4, regrt4, m2reg4, jal4,
                    shift4, sext4, alusrca4, alusrcb4, aluc4, pcsource4};
    else      a = '{state, halted, wpc, wir, wmem, wreg, iord, regrt, m2reg, jal,
                    shift, sext, alusrca, alusrcb, aluc, pcsource};
    return a;
  endfunction

  // Expected outputs for one cycle of a named instruction in a given phase.
  function automatic out_t exp_out(input int ph, input int idx, input logic zz, input logic r);
    out_t  e = '0;
    int    k = (idx < 0) ? 0 : idx;
    string nm = (idx < 0) ? "illegal" : vt[k].nm;
    logic  br = (nm == "beq" || nm == "bne");
    e.state  = 3'(ph);
    e.halted = (ph == 5);
    case (ph)
      0: begin e.alusrcb = 2'b01; e.wir = r; e.wpc = r; end
      1: begin
        e.alusrcb = 2'b11;
        e.sext = (idx < 0) ? 1'b0 : vt[k].sext;
        if (nm == "j" || nm == "jal" || nm == "jr") begin
          e.wpc = 1'b1;
          e.pcsource = (nm == "jr") ? 2'b10 : 2'b11;
        end
        if (nm == "jal") begin e.wreg = 1'b1; e.jal = 1'b1; end
      end
      2: begin
        e.alusrca = 1'b1;
        e.sext    = vt[k].sext;
        e.aluc    = vt[k].aluc;
        e.shift   = (nm == "sll" || nm == "srl" || nm == "sra");
        e.alusrcb = (vt[k].op == 6'd0 || br) ? 2'b00 : 2'b10;
        if (br) begin
          e.pcsource = 2'b01;
          e.wpc = (nm == "beq") ? zz : ~zz;
        end
      end
      3: begin e.iord = 1'b1; e.sext = vt[k].sext; e.wmem = (nm == "sw"); end
      4: begin e.wreg = 1'b1; e.regrt = (vt[k].op != 6'd0); e.m2reg = (nm == "lw"); end
      default: ;
    endcase
    return e;
  endfunction

  task automatic chk_out(input string nm, input out_t a, input out_t e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, a, e, $time);
  endtask

  task automatic chk_val(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, a, e, $time);
  endtask

  function automatic logic pick_r();
    return logic'(int'($urandom_range(99)) < rdy_pct);
  endfunction

  function automatic logic pick_z();
    return (zmode < 0) ? logic'($urandom_range(1)) : logic'(zmode[0]);
  endfunction

  // One clock cycle in phase ph: drive, check both instances and the counters, advance.
  task automatic cycle(input int ph, input int idx, input logic r, input logic zz);
    out_t e;
    mem_ready = r;
    z = zz;
    #1;
    e = exp_out(ph, idx, zz, r);
    chk_out($sformatf("out ph%0d op%b", ph, op), act(1'b0), e);
    chk_out($sformatf("out4 ph%0d op%b", ph, op), act(1'b1), e);
    chk_val("instret", instret, cnt_exp);
    chk_val("instret4", {28'd0, instret4}, cnt_exp & 32'hf);
    @(posedge clock);
    #1;
  endtask

  task automatic run_instr(input logic [5:0] o, input logic [5:0] f);
    int    idx = find(o, f);
    string nm;
    logic  r, zz;
    do begin r = pick_r(); cycle(0, idx, r, pick_z()); end while (!r);
    op = o;
    func = f;
    cycle(1, idx, pick_r(), pick_z());
    if (idx < 0) begin
      repeat (20) cycle(5, idx, pick_r(), pick_z());
      return;
    end
    nm = vt[idx].nm;
    if (nm == "j" || nm == "jal" || nm == "jr") begin cnt_exp++; return; end
    zz = pick_z();
    cycle(2, idx, pick_r(), zz);
    if (nm == "beq" || nm == "bne") begin cnt_exp++; return; end
    if (nm == "lw" || nm == "sw") begin
      do begin
        if (mem_stall > 0) begin mem_stall--; r = 1'b0; end
        else r = pick_r();
        cycle(3, idx, r, pick_z());
      end while (!r);
      if (nm == "sw") begin cnt_exp++; return; end
    end
    cycle(4, idx, pick_r(), pick_z());
    cnt_exp++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk_out("reset out", act(1'b0), exp_out(0, 0, z, mem_ready));
    chk_val("reset instret", instret, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    cnt_exp = 0;
  endtask

  initial begin
    int cyc, idx;
    logic [3:0] a_seen;
    logic s_seen;
    fill_table();
    #2;
    do_reset();

    // Table: latency, EXE aluc and ID sext per instruction with memory always ready.
    mem_ready = 1'b1;
    z = 1'b0;
    for (int i = 0; i < 20; i++) begin
      op = vt[i].op;
      func = vt[i].func;
      cyc = 0;
      a_seen = 4'b0000;
      s_seen = 1'b0;
      do begin
        @(posedge clock);
        #1;
        cyc++;
        if (state == 3'd1) s_seen = sext;
        if (state == 3'd2) a_seen = aluc;
      end while (state != 3'd0 && cyc < 12);
      cnt_exp++;
      chk_val({vt[i].nm, " latency"}, cyc, vt[i].lat);
      chk_val({vt[i].nm, " aluc"}, {28'd0, a_seen}, {28'd0, vt[i].aluc});
      chk_val({vt[i].nm, " sext"}, {31'd0, s_seen}, {31'd0, vt[i].sext});
      chk_val({vt[i].nm, " instret"}, instret, cnt_exp);
    end

    // Directed corners with memory ready except where stalled.
    rdy_pct = 100;
    zmode = 0;
    run_instr(6'b000000, 6'b100000);
    mem_stall = 3;
    run_instr(6'b100011, 6'b000000);
    zmode = 1; run_instr(6'b000100, 6'b0);
    zmode = 0; run_instr(6'b000100, 6'b0);
    zmode = 1; run_instr(6'b000101, 6'b0);
    zmode = 0; run_instr(6'b000101, 6'b0);
    run_instr(6'b000011, 6'b0);
    run_instr(6'b111111, 6'b0);
    do_reset();
    run_instr(6'b000000, 6'b111111);
    do_reset();

    // Reset while sw is waiting in MEM with wmem asserted.
    idx = find(6'b101011, 6'b0);
    cycle(0, idx, 1'b1, 1'b0);
    op = 6'b101011;
    cycle(1, idx, 1'b1, 1'b0);
    cycle(2, idx, 1'b1, 1'b0);
    mem_ready = 1'b0;
    #1;
    chk_out("sw mem wait", act(1'b0), exp_out(3, idx, 1'b0, 1'b0));
    #2;
    reset = 1'b1;
    #1;
    chk_out("sw async reset", act(1'b0), exp_out(0, idx, 1'b0, 1'b0));
    chk_val("sw reset instret", instret, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    cnt_exp = 0;

    // 17 adds: 4-bit counter wraps to 1.
    repeat (17) run_instr(6'b000000, 6'b100000);
    chk_val("wrap instret4", {28'd0, instret4}, 1);
    chk_val("wrap instret", instret, 17);

    // Random stream with flaky memory, random z, junk func on I-types, rare illegal ops.
    rdy_pct = 70;
    zmode = -1;
    repeat (300) begin
      if ($urandom_range(99) < 3) begin
        run_instr(6'b111111, 6'($urandom));
        do_reset();
      end else begin
        idx = int'($urandom_range(19));
        if ($urandom_range(9) == 0 && vt[idx].op == 6'b100011) mem_stall = 2;
        run_instr(vt[idx].op, (vt[idx].op == 6'd0) ? vt[idx].func : 6'($urandom));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
